// File: rtl/mio_bus_responder.sv
// Memory/IO responder for the multicycle CPU: decodes each access, inserts
// WAIT_CYCLES wait states, then serves it from a word RAM or the peripheral
// registers (switches, LEDs, free-running cycle counter).
module mio_bus_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] M_addr,
    input  logic [31:0] data_out,
    output logic [31:0] data2CPU,
    output logic        MIO_ready,
    output logic        bus_err,
    input  logic [15:0] sw,
    output logic [15:0] led
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [2**ADDR_W];

    logic        req;
    logic        perform;
    logic [3:0]  region;
    logic        sel_ram, sel_sw, sel_led, sel_cyc, sel_none;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0] rd_val;
    logic        unused_addr;

    assign req         = mem_r | mem_w;
    assign region      = M_addr[31:28];
    assign ram_idx     = M_addr[ADDR_W+1:2];
    assign unused_addr = ^{M_addr[27:ADDR_W+2], M_addr[1:0]};

    assign sel_ram  = (region == 4'h0);
    assign sel_sw   = (region == 4'hE);
    assign sel_led  = (region == 4'hF) & ~M_addr[2];
    assign sel_cyc  = (region == 4'hF) & M_addr[2];
    assign sel_none = ~(sel_ram | sel_sw | sel_led | sel_cyc);

    // The edge that actually carries out the access.
    assign perform = ((state_q == StIdle) && req && (WAIT_CYCLES == 0)) ||
                     ((state_q == StWait) && (wait_q == 4'd1));

    // Read data selection for the decoded region.
    always_comb begin
        rd_val = 32'h0;
        if (sel_ram) begin
            rd_val = mem_q[ram_idx];
        end else if (sel_sw) begin
            rd_val = {16'h0, sw};
        end else if (sel_led) begin
            rd_val = {16'h0, led_q};
        end else if (sel_cyc) begin
            rd_val = cyc_q;
        end
    end

    // FSM next state, wait counter and MIO_ready.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        MIO_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                MIO_ready = ~req;
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = StDone;
                    end else begin
                        wait_d  = WaitLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                MIO_ready = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath effects of a performed access.
    always_comb begin
        rdata_d = rdata_q;
        led_d   = led_q;
        err_d   = 1'b0;
        cyc_d   = cyc_q + 32'd1;
        if (perform) begin
            err_d = sel_none;
            if (mem_w) begin
                // Simultaneous read+write is a write; the read port reports 0.
                if (mem_r) begin
                    rdata_d = 32'h0;
                end
                if (sel_led) begin
                    led_d = data_out[15:0];
                end
                if (sel_cyc) begin
                    cyc_d = 32'h0;
                end
            end else if (mem_r) begin
                rdata_d = rd_val;
            end
        end
    end

    // State and peripheral registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            cyc_q   <= 32'h0;
            rdata_q <= 32'h0;
            led_q   <= 16'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            err_q   <= err_d;
        end
    end

    // Word RAM; contents survive reset, and no write lands while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && perform && mem_w && sel_ram) begin
            mem_q[ram_idx] <= data_out;
        end
    end

    assign data2CPU = rdata_q;
    assign led      = led_q;
    assign bus_err  = err_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder: a WAIT_CYCLES=2 instance for the
// main checks plus a WAIT_CYCLES=0 instance for back-to-back timing.
module tb_mio_bus_responder;

    localparam int unsigned AW   = 10;
    localparam int unsigned WC   = 2;
    localparam int unsigned GAP  = 4;

    typedef struct {
        logic [31:0] d2c;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_r, mem_w;
    logic [31:0] m_addr, wdata;
    logic [31:0] d2c;
    logic        ready, bus_err;
    logic [15:0] sw, led;

    logic        mem_r0, mem_w0;
    logic [31:0] m_addr0, wdata0, d2c0;
    logic        ready0, bus_err0;
    logic [15:0] led0;

    exp_t        sb[$];
    logic [31:0] model_d2c;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mio_bus_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .mem_r     (mem_r),
        .mem_w     (mem_w),
        .M_addr    (m_addr),
        .data_out  (wdata),
        .data2CPU  (d2c),
        .MIO_ready (ready),
        .bus_err   (bus_err),
        .sw        (sw),
        .led       (led)
    );

    mio_bus_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .mem_r     (mem_r0),
        .mem_w     (mem_w0),
        .M_addr    (m_addr0),
        .data_out  (wdata0),
        .data2CPU  (d2c0),
        .MIO_ready (ready0),
        .bus_err   (bus_err0),
        .sw        (sw),
        .led       (led0)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU access on u_dut, started from IDLE at a negedge; returns at the
    // following IDLE negedge with the request dropped.
    task automatic access(input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input string tag);
        exp_t e;
        int   low;
        bit   done;
        if (w && r)  model_d2c = 32'h0;
        else if (r)  model_d2c = exp_rd;
        e.d2c = model_d2c;
        e.err = exp_err;
        sb.push_back(e);
        mem_r  = r;
        mem_w  = w;
        m_addr = addr;
        wdata  = wd;
        low    = 0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
            else       low++;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        if (done) begin
            e = sb.pop_front();
            check_eq({tag, "_wait"}, 32'(low), 32'(WC));
            check_eq({tag, "_data"}, d2c, e.d2c);
            check_eq({tag, "_err"}, 32'(bus_err), 32'(e.err));
        end
        mem_r = 1'b0;
        mem_w = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        mem_r   = 1'b0; mem_w  = 1'b0; m_addr  = 32'h0; wdata  = 32'h0;
        mem_r0  = 1'b0; mem_w0 = 1'b0; m_addr0 = 32'h0; wdata0 = 32'h0;
        sw      = 16'h0;
        model_d2c = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_led", 32'(led), 32'h0);
        check_eq("rst_data", d2c, 32'h0);
        check_eq("rst_err", 32'(bus_err), 32'd0);

        // RAM write/read and aliasing.
        access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, "ram_wr");
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "ram_rd");
        access(1'b1, 1'b0, 32'h0000_0010 + 32'(4 * (2 ** AW)), 32'h0, 32'hDEAD_BEEF,
               1'b0, "ram_alias");

        // Peripherals.
        access(1'b0, 1'b1, 32'hF000_0000, 32'h0000_A5A5, 32'h0, 1'b0, "led_wr");
        check_eq("led_val", 32'(led), 32'h0000_A5A5);
        sw = 16'h1234;
        access(1'b1, 1'b0, 32'hE000_0000, 32'h0, 32'h0000_1234, 1'b0, "sw_rd");
        access(1'b0, 1'b1, 32'hE000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, "sw_wr");
        access(1'b1, 1'b0, 32'hF000_0000, 32'h0, 32'h0000_A5A5, 1'b0, "led_rd");

        // Cycle counter clear then read after a known idle gap.
        access(1'b0, 1'b1, 32'hF000_0004, 32'h1357_9BDF, 32'h0, 1'b0, "cyc_clr");
        repeat (GAP) @(negedge clk);
        access(1'b1, 1'b0, 32'hF000_0004, 32'h0, 32'(GAP + WC + 1), 1'b0, "cyc_rd");

        // Counter wrap.
        force u_dut.cyc_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_dut.cyc_q;
        @(negedge clk);
        check_eq("cyc_wrap", u_dut.cyc_q, 32'h0);

        // Unmapped region: zero data and a one-cycle bus_err in DONE.
        access(1'b1, 1'b0, 32'h5000_0000, 32'h0, 32'h0, 1'b1, "unmapped");
        check_eq("err_pulse_end", 32'(bus_err), 32'd0);

        // Read+write together is a write with data2CPU forced to 0.
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "pre_both");
        access(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 1'b0, "both");
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0, "both_rd");

        // Reset in WAIT abandons the pending write.
        mem_w  = 1'b1;
        m_addr = 32'h0000_0010;
        wdata  = 32'h0BAD_F00D;
        @(negedge clk);
        check_eq("in_wait", 32'(ready), 32'd0);
        reset = 1'b1;
        mem_w = 1'b0;
        #1;
        check_eq("rst_idle", 32'(ready), 32'd1);
        check_eq("rst_data2", d2c, 32'h0);
        model_d2c = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "rst_ram");

        // Zero wait states: request held, ready toggles 0,1,0,1.
        sw      = 16'hBEEF;
        mem_r0  = 1'b1;
        m_addr0 = 32'hE000_0000;
        #1;
        check_eq("w0_r0", 32'(ready0), 32'd0);
        @(negedge clk);
        check_eq("w0_r1", 32'(ready0), 32'd1);
        check_eq("w0_data", d2c0, 32'h0000_BEEF);
        @(negedge clk);
        check_eq("w0_r2", 32'(ready0), 32'd0);
        @(negedge clk);
        check_eq("w0_r3", 32'(ready0), 32'd1);
        mem_r0 = 1'b0;
        @(negedge clk);
        check_eq("w0_idle", 32'(ready0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
